post_add_acc: RTL and testbench
===============================

POST_ADD_ACC -- requirements
Module: post_add_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 48, post-adder/accumulator datapath width in bits.
REQ-002 SHALL have parameter SUB_CIN_POL, default 1, CIN polarity in subtract mode: 1 means the result is Z-(X+CIN).
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 X_IN  input  WIDTH  X-multiplexer output operand.
REQ-006 Z_IN  input  WIDTH  Z-multiplexer output operand.
REQ-007 CIN  input  1  carry-in.
REQ-008 SUB  input  1  0 means add, 1 means subtract.
REQ-009 IN_VALID  input  1  operands valid this cycle.
REQ-010 CE  input  1  clock enable for both stages; when low, all state holds.
REQ-011 ACC_CLR  input  1  synchronous clear of the result register.
REQ-012 P  output  WIDTH  registered result.
REQ-013 CARRYOUT  output  1  registered carry (add) or borrow (subtract) out of bit WIDTH-1.
REQ-014 P_VALID  output  1  P holds a result produced from a valid operand set.
REQ-015 OVF  output  1  sticky signed-overflow flag.

Function
REQ-016 Stage 1 SHALL register X_IN, Z_IN, CIN, SUB and IN_VALID when CE=1.
REQ-017 Stage 2 SHALL compute from the stage-1 registers and register P, CARRYOUT, P_VALID and OVF when CE=1.
REQ-018 Latency SHALL be 2 CE-enabled cycles from IN_VALID sampled high to P_VALID high.
REQ-019 Throughput SHALL be one operand set per CE-enabled cycle.
REQ-020 Add SHALL compute sum = Z + X + CIN as a WIDTH+1-bit unsigned value; P = sum[WIDTH-1:0]; CARRYOUT = sum[WIDTH].
REQ-021 Subtract SHALL compute diff = Z - (X + CIN) as WIDTH+1 bits; P = diff[WIDTH-1:0]; CARRYOUT = diff[WIDTH], which is 1 on borrow.
REQ-022 Signed overflow SHALL be detected as follows. Add: X and Z have the same sign and the result sign differs from it. Subtract: X and Z have different signs and the result sign differs from Z's sign.
REQ-023 When the stage-1 valid register is 0 and CE=1, stage 2 SHALL hold P, CARRYOUT and OVF and SHALL clear P_VALID to 0.
REQ-024 When CE=0, every register SHALL hold, including P_VALID; IN_VALID is ignored, so an operand set presented while CE=0 is dropped.
REQ-025 ACC_CLR=1 with CE=1 SHALL set P=0, CARRYOUT=0, OVF=0 and P_VALID=0 on that edge, overriding any stage-2 result.
REQ-026 ACC_CLR SHALL NOT flush stage 1; an operand set held in stage 1 completes on the next CE-enabled edge.
REQ-027 ACC_CLR with CE=0 SHALL have no effect.
REQ-028 Accumulation is performed externally by routing P back through the Z multiplexer; the block SHALL have no combinational path from any input to any output.

Reset
REQ-029 RST_N low SHALL immediately clear all stage-1 registers, P, CARRYOUT, P_VALID and OVF to 0, independent of CLK and CE.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight operand set; the first P_VALID after deassertion comes from IN_VALID sampled after deassertion.
REQ-031 Reset deassertion SHALL be synchronised externally; the block adds no reset synchroniser.

Configuration
REQ-032 The macro POST_ADD_ACC_SAT_EN SHALL select saturation and sticky overflow.
REQ-033 With POST_ADD_ACC_SAT_EN defined, an overflowing result SHALL saturate P: 2^(WIDTH-1)-1 on positive overflow, -2^(WIDTH-1) on negative overflow.
REQ-034 With POST_ADD_ACC_SAT_EN defined, OVF SHALL be set and held until ACC_CLR or reset, and CARRYOUT is still computed from the unsaturated result.
REQ-035 Without POST_ADD_ACC_SAT_EN, P SHALL wrap modulo 2^WIDTH and OVF SHALL be tied to 0.

Verification
REQ-036 Add: WIDTH=48, X=5, Z=10, CIN=1, SUB=0, IN_VALID=1, CE=1 -> after 2 edges, P=16, CARRYOUT=0, P_VALID=1.
REQ-037 Subtract with borrow: X=20, Z=10, CIN=0, SUB=1 -> P=0xFFFF_FFFF_FFF6, CARRYOUT=1.
REQ-038 Overflow: X=Z=0x7FFF_FFFF_FFFF, add -> with macro, P=0x7FFF_FFFF_FFFF and OVF=1, still set 3 cycles later; without macro, P=0xFFFF_FFFF_FFFE and OVF=0.
REQ-039 CE stall: three back-to-back valid sets with CE=0 for 2 cycles between the 2nd and 3rd -> P, P_VALID and OVF frozen during the stall; the 3rd result appears 2 enabled edges after its capture; no result is lost or duplicated.
REQ-040 ACC_CLR/reset: ACC_CLR=1 with a valid set in stage 1 -> P=0 and P_VALID=0, then the stage-1 result next edge; RST_N pulsed low mid-stream -> all outputs 0 immediately, no stale P_VALID.

Source files
------------

// File: rtl/post_add_acc.sv
// post_add_acc: two-stage post-adder / accumulator datapath.
// Stage 1 registers the operands and the valid flag. Stage 2 registers the result, the
// carry/borrow and the valid flag. Accumulation is done outside the block by feeding P
// back through the Z multiplexer.
// Optional feature macro: POST_ADD_ACC_SAT_EN enables saturation and sticky overflow.
// Without it, P wraps modulo 2^WIDTH and OVF is tied low.
module post_add_acc #(
    parameter int unsigned WIDTH       = 48,
    parameter bit          SUB_CIN_POL = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] Z_IN,
    input  logic             CIN,
    input  logic             SUB,
    input  logic             IN_VALID,
    input  logic             CE,
    input  logic             ACC_CLR,
    output logic [WIDTH-1:0] P,
    output logic             CARRYOUT,
    output logic             P_VALID,
    output logic             OVF
);

    // Stage-1 operand registers
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             cin_q, cin_d;
    logic             sub_q, sub_d;
    logic             vld_q, vld_d;

    // Stage-2 result registers
    logic [WIDTH-1:0] p_q, p_d;
    logic             co_q, co_d;
    logic             pv_q, pv_d;

    // Datapath
    logic             cin_eff;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] res;

`ifdef POST_ADD_ACC_SAT_EN
    logic             ovf_q, ovf_d;
    logic             ovf_now;
    logic [WIDTH-1:0] sat_max;
    logic [WIDTH-1:0] sat_min;
`endif

    // Stage 1 captures the operand set on every enabled edge
    always_comb begin
        x_d   = x_q;
        z_d   = z_q;
        cin_d = cin_q;
        sub_d = sub_q;
        vld_d = vld_q;
        if (CE) begin
            x_d   = X_IN;
            z_d   = Z_IN;
            cin_d = CIN;
            sub_d = SUB;
            vld_d = IN_VALID;
        end
    end

    // Add/subtract on WIDTH+1 bits so the top bit is the carry (add) or borrow (subtract)
    always_comb begin
        // With SUB_CIN_POL=0 the subtract carry is active-low: Z - (X + ~CIN)
        cin_eff = (sub_q && !SUB_CIN_POL) ? ~cin_q : cin_q;
        cin_ext = {{WIDTH{1'b0}}, cin_eff};
        if (sub_q) begin
            full = {1'b0, z_q} - ({1'b0, x_q} + cin_ext);
        end else begin
            full = {1'b0, z_q} + {1'b0, x_q} + cin_ext;
        end
        res = full[WIDTH-1:0];
`ifdef POST_ADD_ACC_SAT_EN
        sat_max = {1'b0, {(WIDTH-1){1'b1}}};
        sat_min = {1'b1, {(WIDTH-1){1'b0}}};
        if (sub_q) begin
            ovf_now = (x_q[WIDTH-1] != z_q[WIDTH-1]) && (full[WIDTH-1] != z_q[WIDTH-1]);
        end else begin
            ovf_now = (x_q[WIDTH-1] == z_q[WIDTH-1]) && (full[WIDTH-1] != z_q[WIDTH-1]);
        end
        // In both modes an overflow goes in the direction of Z's sign
        if (ovf_now) begin
            res = z_q[WIDTH-1] ? sat_min : sat_max;
        end
`endif
    end

    // Stage 2: clear wins, then a valid set loads, otherwise results hold and valid drops
    always_comb begin
        p_d  = p_q;
        co_d = co_q;
        pv_d = pv_q;
`ifdef POST_ADD_ACC_SAT_EN
        ovf_d = ovf_q;
`endif
        if (CE) begin
            if (ACC_CLR) begin
                p_d  = '0;
                co_d = 1'b0;
                pv_d = 1'b0;
`ifdef POST_ADD_ACC_SAT_EN
                ovf_d = 1'b0;
`endif
            end else if (vld_q) begin
                p_d  = res;
                co_d = full[WIDTH];
                pv_d = 1'b1;
`ifdef POST_ADD_ACC_SAT_EN
                ovf_d = ovf_q | ovf_now;
`endif
            end else begin
                pv_d = 1'b0;
            end
        end
    end

    // Stage-1 and stage-2 state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q   <= '0;
            z_q   <= '0;
            cin_q <= 1'b0;
            sub_q <= 1'b0;
            vld_q <= 1'b0;
            p_q   <= '0;
            co_q  <= 1'b0;
            pv_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            z_q   <= z_d;
            cin_q <= cin_d;
            sub_q <= sub_d;
            vld_q <= vld_d;
            p_q   <= p_d;
            co_q  <= co_d;
            pv_q  <= pv_d;
        end
    end

`ifdef POST_ADD_ACC_SAT_EN
    // Sticky overflow register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    assign P        = p_q;
    assign CARRYOUT = co_q;
    assign P_VALID  = pv_q;

endmodule

// File: tb/tb_post_add_acc.sv
// Self-checking bench for post_add_acc (default WIDTH=48, SUB_CIN_POL=1).
// Define POST_ADD_ACC_SAT_EN for both bench and RTL to check the saturating build.
module tb_post_add_acc;

    localparam int W = 48;

    typedef struct packed {
        logic [W-1:0] p;
        logic         co;
        logic         ovf;
    } res_t;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] X_IN = '0;
    logic [W-1:0] Z_IN = '0;
    logic         CIN = 1'b0;
    logic         SUB = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         CE = 1'b0;
    logic         ACC_CLR = 1'b0;
    logic [W-1:0] P;
    logic         CARRYOUT;
    logic         P_VALID;
    logic         OVF;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: the operand set waiting in the pipe and the visible outputs
    logic         m_v;
    logic [W-1:0] m_x, m_z;
    logic         m_cin, m_sub;
    logic [W-1:0] m_p;
    logic         m_co, m_pv, m_ovf;

    post_add_acc dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .X_IN     (X_IN),
        .Z_IN     (Z_IN),
        .CIN      (CIN),
        .SUB      (SUB),
        .IN_VALID (IN_VALID),
        .CE       (CE),
        .ACC_CLR  (ACC_CLR),
        .P        (P),
        .CARRYOUT (CARRYOUT),
        .P_VALID  (P_VALID),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    function automatic res_t ref_calc(logic [W-1:0] x, logic [W-1:0] z, logic c, logic s);
        res_t         r;
        logic [W:0]   full;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        mx = '1;
        mx[W-1] = 1'b0;
        mn = '0;
        mn[W-1] = 1'b1;
        if (s) full = {1'b0, z} - {1'b0, x} - c;
        else   full = {1'b0, z} + {1'b0, x} + c;
        r.p  = full[W-1:0];
        r.co = full[W];
        if (s) r.ovf = (x[W-1] != z[W-1]) && (full[W-1] != z[W-1]);
        else   r.ovf = (x[W-1] == z[W-1]) && (full[W-1] != z[W-1]);
`ifdef POST_ADD_ACC_SAT_EN
        if (r.ovf) r.p = z[W-1] ? mn : mx;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_v = 0; m_x = '0; m_z = '0; m_cin = 0; m_sub = 0;
        m_p = '0; m_co = 0; m_pv = 0; m_ovf = 0;
    endtask

    // One clock edge: advance the model with the inputs the DUT sees, then settle
    task automatic tick();
        res_t r;
        @(posedge CLK);
        if (CE) begin
            if (ACC_CLR) begin
                m_p = '0; m_co = 0; m_pv = 0; m_ovf = 0;
            end else if (m_v) begin
                r = ref_calc(m_x, m_z, m_cin, m_sub);
                m_p = r.p;
                m_co = r.co;
                m_pv = 1;
`ifdef POST_ADD_ACC_SAT_EN
                m_ovf = m_ovf | r.ovf;
`else
                m_ovf = 0;
`endif
            end else begin
                m_pv = 0;
            end
            m_v = IN_VALID; m_x = X_IN; m_z = Z_IN; m_cin = CIN; m_sub = SUB;
        end
        #1;
    endtask

    task automatic drive(input logic ce, input logic v, input logic [W-1:0] x,
                         input logic [W-1:0] z, input logic c, input logic s,
                         input logic clr);
        CE = ce; IN_VALID = v; X_IN = x; Z_IN = z; CIN = c; SUB = s; ACC_CLR = clr;
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: ;
            1: begin v = '1; v[W-1] = 1'b0; v = v - W'($urandom_range(0, 3)); end
            2: begin v = '0; v[W-1] = 1'b1; v = v + W'($urandom_range(0, 3)); end
            default: v = W'($urandom_range(0, 40));
        endcase
        return v;
    endfunction

    task automatic test_reset();
        model_reset();
        drive(1, 1, 48'd7, 48'd9, 1, 0, 0);
        #3;
        n_checks++;
        if ({P, CARRYOUT, P_VALID, OVF} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: P=%h CO=%b PV=%b OVF=%b, expected all 0",
                     P, CARRYOUT, P_VALID, OVF);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (P_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: PV=%b, expected 0", P_VALID);
        end
    endtask

    task automatic test_add();
        drive(1, 1, 48'd5, 48'd10, 1, 0, 0);
        tick();
        drive(1, 0, '0, '0, 0, 0, 0);
        n_checks++;
        if (P_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL add_latency1: PV=%b, expected 0", P_VALID);
        end
        tick();
        n_checks++;
        if ({P, CARRYOUT, P_VALID} !== {48'd16, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_basic: P=%h CO=%b PV=%b, expected P=%h CO=0 PV=1",
                     P, CARRYOUT, P_VALID, 48'd16);
        end
        tick();
        n_checks++;
        if ({P, P_VALID} !== {48'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL add_hold: P=%h PV=%b, expected P=%h PV=0", P, P_VALID, 48'd16);
        end
    endtask

    task automatic test_sub_borrow();
        drive(1, 1, 48'd20, 48'd10, 0, 1, 0);
        tick();
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        n_checks++;
        if ({P, CARRYOUT, P_VALID} !== {48'hFFFF_FFFF_FFF6, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_borrow: P=%h CO=%b PV=%b, expected P=fffffffffff6 CO=1 PV=1",
                     P, CARRYOUT, P_VALID);
        end
        drive(1, 1, 48'd3, 48'd10, 1, 1, 0);
        tick();
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        n_checks++;
        if ({P, CARRYOUT} !== {48'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_cin: P=%h CO=%b, expected P=6 CO=0", P, CARRYOUT);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_p;
        logic         exp_o;
`ifdef POST_ADD_ACC_SAT_EN
        exp_p = 48'h7FFF_FFFF_FFFF;
        exp_o = 1'b1;
`else
        exp_p = 48'hFFFF_FFFF_FFFE;
        exp_o = 1'b0;
`endif
        drive(1, 1, 48'h7FFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF, 0, 0, 0);
        tick();
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        n_checks++;
        if ({P, OVF, P_VALID} !== {exp_p, exp_o, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_result: P=%h OVF=%b PV=%b, expected P=%h OVF=%b PV=1",
                     P, OVF, P_VALID, exp_p, exp_o);
        end
        // A non-overflowing result must not clear the sticky flag
        drive(1, 1, 48'd1, 48'd2, 0, 0, 0);
        tick();
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if ({P, OVF} !== {48'd3, exp_o}) begin
            n_fail++;
            $display("FAIL ovf_sticky: P=%h OVF=%b, expected P=3 OVF=%b", P, OVF, exp_o);
        end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        drive(1, 1, 48'd100, 48'd1, 0, 0, 0);
        tick();
        drive(1, 1, 48'd200, 48'd2, 0, 0, 0);
        tick();
        if (P_VALID) seen++;
        n_checks++;
        if ({P, P_VALID} !== {48'd101, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_first: P=%h PV=%b, expected P=%h PV=1", P, P_VALID, 48'd101);
        end
        // Stalled cycles: a valid set shown while CE=0 is dropped, outputs frozen
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 48'hDEAD, 48'hBEEF, 1, 1, 0);
            tick();
            n_checks++;
            if ({P, P_VALID, OVF} !== {48'd101, 1'b1, m_ovf}) begin
                n_fail++;
                $display("FAIL b2b_stall%0d: P=%h PV=%b OVF=%b, expected P=%h PV=1 OVF=%b",
                         i, P, P_VALID, OVF, 48'd101, m_ovf);
            end
        end
        drive(1, 1, 48'd300, 48'd3, 0, 0, 0);
        tick();
        if (P_VALID) seen++;
        n_checks++;
        if ({P, P_VALID} !== {48'd202, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second: P=%h PV=%b, expected P=%h PV=1", P, P_VALID, 48'd202);
        end
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        if (P_VALID) seen++;
        n_checks++;
        if ({P, P_VALID} !== {48'd303, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_third: P=%h PV=%b, expected P=%h PV=1", P, P_VALID, 48'd303);
        end
        tick();
        if (P_VALID) seen++;
        n_checks++;
        if (seen != 3) begin
            n_fail++;
            $display("FAIL b2b_count: results=%0d, expected 3", seen);
        end
    endtask

    task automatic test_clr();
        drive(1, 1, 48'd40, 48'd2, 0, 0, 0);
        tick();
        drive(1, 1, 48'd50, 48'd5, 0, 0, 1);
        tick();
        n_checks++;
        if ({P, CARRYOUT, P_VALID, OVF} !== '0) begin
            n_fail++;
            $display("FAIL clr_override: P=%h CO=%b PV=%b OVF=%b, expected all 0",
                     P, CARRYOUT, P_VALID, OVF);
        end
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        n_checks++;
        if ({P, P_VALID} !== {48'd55, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_stage1_kept: P=%h PV=%b, expected P=%h PV=1",
                     P, P_VALID, 48'd55);
        end
        drive(0, 0, '0, '0, 0, 0, 1);
        tick();
        n_checks++;
        if ({P, P_VALID} !== {48'd55, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_no_ce: P=%h PV=%b, expected P=%h PV=1", P, P_VALID, 48'd55);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 8), $urandom_range(0, 1), rnd_val(), rnd_val(),
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 29) == 0));
            tick();
            n_checks++;
            if ({P, CARRYOUT, P_VALID, OVF} !== {m_p, m_co, m_pv, m_ovf}) begin
                n_fail++;
                $display("FAIL random[%0d]: P=%h CO=%b PV=%b OVF=%b, expected P=%h CO=%b PV=%b OVF=%b",
                         i, P, CARRYOUT, P_VALID, OVF, m_p, m_co, m_pv, m_ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 48'd11, 48'd22, 0, 0, 0);
        tick();
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({P, CARRYOUT, P_VALID, OVF} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: P=%h CO=%b PV=%b OVF=%b, expected all 0",
                     P, CARRYOUT, P_VALID, OVF);
        end
        drive(1, 0, '0, '0, 0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({P, P_VALID} !== {48'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_no_stale%0d: P=%h PV=%b, expected P=0 PV=0",
                         i, P, P_VALID);
            end
        end
        drive(1, 1, 48'd4, 48'd4, 0, 0, 0);
        tick();
        drive(1, 0, '0, '0, 0, 0, 0);
        tick();
        n_checks++;
        if ({P, P_VALID} !== {48'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_first_result: P=%h PV=%b, expected P=8 PV=1", P, P_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_borrow();
        test_overflow();
        test_back_to_back();
        test_clr();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
